// File: rtl/kevin_gen_if.sv
// kevin_gen_if: valid/ready stream carrying one Kevin number per transfer
// master drives out_valid, out, out_idx; slave drives out_ready.
interface kevin_gen_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out;
  logic [2:0] out_idx;
  modport master (output out_valid, out, out_idx, input out_ready);
  modport slave (input out_valid, out, out_idx, output out_ready);
endinterface

// File: rtl/kevin_gen.sv
// kevin_gen: steps through the Kevin number set {1,5,6,7,9,10,12,14} on a valid/ready stream
// Ports: clk, rst (async, active-high); en run request; dir 1=ascending 0=descending;
// load/load_val seed the index in IDLE (snapped to the set); s stream (out_valid, out_ready,
// out, out_idx); wrap one-cycle pulse after an index wrap; lap_cnt wraps since reset.
module kevin_gen #(
  parameter int START_IDX = 0,
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [3:0]       load_val,
  kevin_gen_if.master      s,
  output logic             wrap,
  output logic [LAP_W-1:0] lap_cnt
);
  localparam logic [31:0] TBL = {4'd14, 4'd12, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd1};
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [2:0] idx, idx_n, snap_up, snap_dn;
  logic wrap_n;
  logic [LAP_W-1:0] lap_n;
  logic hs;
  // snap_up: smallest member >= load_val (15 falls back to idx 0);
  // snap_dn: largest member <= load_val (0 falls back to idx 7)
  always_comb begin
    snap_up = 3'd0;
    snap_dn = 3'd7;
    for (int i = 7; i >= 0; i--)
      if (TBL[i*4 +: 4] >= load_val) snap_up = 3'(i);
    for (int i = 0; i < 8; i++)
      if (TBL[i*4 +: 4] <= load_val) snap_dn = 3'(i);
  end
  assign hs = (state == ACTIVE) && s.out_ready;
  always_comb begin
    state_n = state;
    idx_n = idx;
    wrap_n = 1'b0;
    lap_n = lap_cnt;
    if (state == IDLE) begin
      if (load) idx_n = dir ? snap_up : snap_dn;
      else if (en) state_n = ACTIVE;
    end else if (hs) begin
      idx_n = dir ? idx + 3'd1 : idx - 3'd1;
      wrap_n = dir ? (idx == 3'd7) : (idx == 3'd0);
      lap_n = lap_cnt + LAP_W'(wrap_n);
      state_n = en ? ACTIVE : IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= 3'(START_IDX);
      wrap <= 1'b0;
      lap_cnt <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      wrap <= wrap_n;
      lap_cnt <= lap_n;
    end
  assign s.out_valid = (state == ACTIVE);
  assign s.out_idx = idx;
  assign s.out = TBL[{idx, 2'b00} +: 4];
endmodule
